regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of writeback requesters (2..4).
REQ-002 Parameter AW, default 5, SHALL set the register address width.
REQ-003 Parameter DW, default 32, SHALL set the data width.
REQ-004 clock  in  1  SHALL be the single clock; all state SHALL be updated on posedge clock.
REQ-005 reset  in  1  SHALL be asynchronous and active-high.
REQ-006 req_valid  in  NREQ  SHALL carry the per-requester writeback request.
REQ-007 req_ready  out  NREQ  SHALL be the per-requester grant; it is one-hot or zero.
REQ-008 req_addr  in  NREQ*AW  SHALL be the packed destination register, with requester i at [i*AW +: AW].
REQ-009 req_data  in  NREQ*DW  SHALL be the packed write data, with requester i at [i*DW +: DW].
REQ-010 claim_valid  in  1  SHALL be driven by issue to mark a destination pending.
REQ-011 claim_addr  in  AW  SHALL be the register being claimed.
REQ-012 busy  out  2**AW  SHALL be the scoreboard, where busy[r]=1 means a write to r is outstanding.
REQ-013 RegWrite  out  1  SHALL be the register file write enable.
REQ-014 WriteAddr  out  AW  SHALL be the register file write address.
REQ-015 WriteData  out  DW  SHALL be the register file write data.
REQ-016 grant_id  out  2  SHALL identify the requester whose write is on RegWrite/WriteAddr/WriteData this cycle.

Function
REQ-017 Arbitration SHALL be round-robin with pointer ptr:
- search from ptr upward, modulo NREQ;
- grant the first i with req_valid[i]=1;
- req_ready is combinational from req_valid and ptr.
REQ-018 On a grant to i, ptr SHALL become (i+1) mod NREQ at the next edge; with no grant, ptr SHALL hold.
REQ-019 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1; at most one transfer per cycle.
REQ-020 A transfer in cycle N SHALL appear registered in cycle N+1:
- RegWrite=1;
- WriteAddr and WriteData = the granted addr and data;
- grant_id = i.
REQ-021 Latency SHALL be 1 cycle and throughput 1 write per cycle; there is no downstream backpressure.
REQ-022 In any cycle with no transfer, RegWrite SHALL be 0 at the next edge; WriteAddr, WriteData and grant_id SHALL hold.
REQ-023 A transfer with addr 0 SHALL complete the handshake, and RegWrite SHALL remain 0 for it.
REQ-024 Requesters SHALL hold req_valid, addr and data stable until ready; the block need not tolerate withdrawal.
REQ-025 claim_valid=1 with claim_addr=r, r!=0, SHALL set busy[r] at the next edge.
REQ-026 An issued write, RegWrite=1 with WriteAddr=r, SHALL clear busy[r] at the next edge.
REQ-027 A simultaneous claim and clear of the same r SHALL leave busy[r]=1 (claim wins).
REQ-028 Claim and clear of different registers in the same cycle SHALL both take effect.
REQ-029 busy[0] SHALL be constant 0.
REQ-030 A claim of an already-busy register SHALL leave it busy; there is no counting.

Reset
REQ-031 Asserting reset SHALL immediately force:
- RegWrite=0, WriteAddr=0, WriteData=0;
- grant_id=0, ptr=0, busy=0.
REQ-032 A transfer granted in the cycle reset asserts SHALL be discarded and no write SHALL issue.
REQ-033 While reset is high, req_ready SHALL be all-zero.

Structure
REQ-034 Shared package regfile_pkg SHALL hold AW, DW, NREQ and the requester IDs: ID_ALU=0, ID_LOAD=1, ID_MDU=2.
REQ-035 Round-robin grant logic SHALL be a sub-module rr_arbiter with inputs req and ptr and outputs grant (one-hot) and grant_idx.
REQ-036 The scoreboard and the output register SHALL live in regfile_wb_arbiter.

Verification
REQ-037 Reset state: after reset, with all requesters valid (addrs 1/2/3), the bench SHALL see:
- grants in order 0,1,2,0;
- RegWrite=1 each cycle from one cycle after the first grant;
- WriteAddr sequence 1,2,3,1.
REQ-038 Single requester: req 1 valid, addr 7, data 0xDEADBEEF for one cycle -> next cycle RegWrite=1, WriteAddr=7, WriteData=0xDEADBEEF, grant_id=1; the following cycle RegWrite=0.
REQ-039 Address 0: req 0 valid, addr 0, data 0x1234 -> req_ready[0]=1, and the next cycle RegWrite=0.
REQ-040 Scoreboard: claim r5, then two cycles later a write to 5 -> busy[5]=1 from the claim edge until the edge after RegWrite with WriteAddr=5.
REQ-041 Simultaneous events: claim r9 in the same cycle RegWrite writes 9 -> busy[9]=1 afterwards.
REQ-042 Mid-stream reset: reset asserted while req 2 is granted -> no RegWrite follows, busy=0, and after release the first grant starts from requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing and requester identifiers for the register file writeback path.
package regfile_pkg;
   localparam int unsigned NREQ = 3;
   localparam int unsigned AW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned IDW  = 2;

   typedef enum logic [IDW-1:0] {
      ID_ALU  = 2'd0,
      ID_LOAD = 2'd1,
      ID_MDU  = 2'd2
   } req_id_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned N = NREQ
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_idx
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback requesters onto one registered register-file write port
// and tracks outstanding destinations in a busy scoreboard.
module regfile_wb_arbiter #(
   parameter int unsigned NREQ = regfile_pkg::NREQ,
   parameter int unsigned AW   = regfile_pkg::AW,
   parameter int unsigned DW   = regfile_pkg::DW
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic              claim_valid,
   input  logic [AW-1:0]     claim_addr,
   output logic [2**AW-1:0]  busy,
   output logic              RegWrite,
   output logic [AW-1:0]     WriteAddr,
   output logic [DW-1:0]     WriteData,
   output logic [1:0]        grant_id
);

   localparam int unsigned IDW = regfile_pkg::IDW;

   logic [IDW-1:0]   ptr;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             fire;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_data;
   logic [2**AW-1:0] busy_next;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grant is already qualified by req_valid, so any grant bit is a transfer.
   assign req_ready = reset ? '0 : grant;
   assign fire      = |req_ready;
   assign sel_addr  = req_addr[32'(grant_idx)*AW +: AW];
   assign sel_data  = req_data[32'(grant_idx)*DW +: DW];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         RegWrite  <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
         grant_id  <= '0;
      end else if (fire) begin
         ptr       <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
         RegWrite  <= (sel_addr != '0);
         WriteAddr <= sel_addr;
         WriteData <= sel_data;
         grant_id  <= grant_idx;
      end else begin
         RegWrite  <= 1'b0;
      end
   end

   // Clear is applied before claim so a same-register collision leaves it busy.
   always_comb begin
      busy_next = busy;
      if (RegWrite)
         busy_next[WriteAddr] = 1'b0;
      if (claim_valid)
         busy_next[claim_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_next;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write port timing,
// scoreboard set/clear and reset behaviour.
module tb_regfile_wb_arbiter;

   localparam int unsigned NREQ = 3;
   localparam int unsigned AW   = 5;
   localparam int unsigned DW   = 32;

   logic              clock;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic              claim_valid;
   logic [AW-1:0]     claim_addr;
   logic [2**AW-1:0]  busy;
   logic              RegWrite;
   logic [AW-1:0]     WriteAddr;
   logic [DW-1:0]     WriteData;
   logic [1:0]        grant_id;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .claim_valid (claim_valid),
      .claim_addr  (claim_addr),
      .busy        (busy),
      .RegWrite    (RegWrite),
      .WriteAddr   (WriteAddr),
      .WriteData   (WriteData),
      .grant_id    (grant_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      int g[4] = '{0, 1, 2, 0};
      reset = 1'b1;
      req_valid = '1;
      set_req(0, 5'd1, 32'h1111_0001);
      set_req(1, 5'd2, 32'h2222_0002);
      set_req(2, 5'd3, 32'h3333_0003);
      #3;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0d exp 0", RegWrite); end
      checks++; if (WriteAddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", WriteAddr); end
      checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", WriteData); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
      checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL rr_regwrite[%0d] got %0d exp 1", k-1, RegWrite); end
            checks++; if (WriteAddr !== 5'(g[k-1] + 1)) begin errors++; $display("FAIL rr_waddr[%0d] got %0d exp %0d", k-1, WriteAddr, g[k-1] + 1); end
            checks++; if (grant_id !== 2'(g[k-1])) begin errors++; $display("FAIL rr_grant_id[%0d] got %0d exp %0d", k-1, grant_id, g[k-1]); end
         end
         #1;
         checks++; if (req_ready !== (3'b001 << g[k])) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 3'b001 << g[k]); end
         @(negedge clock);
      end
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL rr_regwrite[3] got %0d exp 1", RegWrite); end
      checks++; if (WriteAddr !== 5'd1) begin errors++; $display("FAIL rr_waddr[3] got %0d exp 1", WriteAddr); end
      checks++; if (WriteData !== 32'h1111_0001) begin errors++; $display("FAIL rr_wdata[3] got %h exp 11110001", WriteData); end
      req_valid = '0;
   endtask

   task automatic test_single();
      @(negedge clock);
      req_valid = 3'b010;
      set_req(1, 5'd7, 32'hDEAD_BEEF);
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", req_ready); end
      @(negedge clock);
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got %0d exp 1", RegWrite); end
      checks++; if (WriteAddr !== 5'd7) begin errors++; $display("FAIL single_waddr got %0d exp 7", WriteAddr); end
      checks++; if (WriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata got %h exp deadbeef", WriteData); end
      checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id got %0d exp 1", grant_id); end
      req_valid = '0;
      @(negedge clock);
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_idle_regwrite got %0d exp 0", RegWrite); end
      checks++; if (WriteAddr !== 5'd7) begin errors++; $display("FAIL single_hold_waddr got %0d exp 7", WriteAddr); end
      checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_hold_grant_id got %0d exp 1", grant_id); end
   endtask

   task automatic test_addr0();
      @(negedge clock);
      req_valid = 3'b001;
      set_req(0, 5'd0, 32'h0000_1234);
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL addr0_ready got %b exp 001", req_ready); end
      @(negedge clock);
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL addr0_regwrite got %0d exp 0", RegWrite); end
      req_valid = '0;
   endtask

   task automatic test_scoreboard();
      @(negedge clock);
      claim_valid = 1'b1;
      claim_addr  = 5'd5;
      @(negedge clock);
      checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL sb_claim got %0d exp 1", busy[5]); end
      claim_valid = 1'b0;
      @(negedge clock);
      checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL sb_hold got %0d exp 1", busy[5]); end
      req_valid = 3'b100;
      set_req(2, 5'd5, 32'hCAFE_0005);
      @(negedge clock);
      checks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd5) begin errors++; $display("FAIL sb_write got we=%0d addr=%0d exp we=1 addr=5", RegWrite, WriteAddr); end
      checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL sb_busy_during_write got %0d exp 1", busy[5]); end
      req_valid = '0;
      @(negedge clock);
      checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL sb_clear got %0d exp 0", busy[5]); end
   endtask

   task automatic test_simultaneous();
      @(negedge clock);
      claim_valid = 1'b1;
      claim_addr  = 5'd12;
      @(negedge clock);
      checks++; if (busy[12] !== 1'b1) begin errors++; $display("FAIL sim_claim12 got %0d exp 1", busy[12]); end
      claim_addr = 5'd9;
      @(negedge clock);
      checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sim_claim9 got %0d exp 1", busy[9]); end
      claim_valid = 1'b0;
      req_valid = 3'b001;
      set_req(0, 5'd9, 32'h0000_0009);
      @(negedge clock);
      checks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd9) begin errors++; $display("FAIL sim_write9 got we=%0d addr=%0d exp we=1 addr=9", RegWrite, WriteAddr); end
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      req_valid = 3'b010;
      set_req(1, 5'd12, 32'h0000_000C);
      @(negedge clock);
      checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sim_claim_wins got %0d exp 1", busy[9]); end
      checks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd12) begin errors++; $display("FAIL sim_write12 got we=%0d addr=%0d exp we=1 addr=12", RegWrite, WriteAddr); end
      claim_addr = 5'd3;
      req_valid = '0;
      @(negedge clock);
      checks++; if (busy[12] !== 1'b0) begin errors++; $display("FAIL sim_clear12 got %0d exp 0", busy[12]); end
      checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL sim_claim3 got %0d exp 1", busy[3]); end
      checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sim_keep9 got %0d exp 1", busy[9]); end
      claim_addr = 5'd0;
      @(negedge clock);
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL sim_busy0 got %0d exp 0", busy[0]); end
      claim_valid = 1'b0;
   endtask

   task automatic test_midstream_reset();
      @(negedge clock);
      req_valid = 3'b111;
      set_req(0, 5'd1, 32'hAAAA_0001);
      set_req(1, 5'd2, 32'hAAAA_0002);
      set_req(2, 5'd3, 32'hAAAA_0003);
      #1;
      checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL mid_ready_pre got %b exp 100", req_ready); end
      #1 reset = 1'b1;
      #1;
      checks++; if (busy !== '0) begin errors++; $display("FAIL mid_busy got %h exp 0", busy); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mid_ready_rst got %b exp 000", req_ready); end
      @(negedge clock);
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mid_discard got %0d exp 0", RegWrite); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_ready_post got %b exp 001", req_ready); end
      @(negedge clock);
      checks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd1 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_first_write got we=%0d addr=%0d id=%0d exp we=1 addr=1 id=0", RegWrite, WriteAddr, grant_id); end
      req_valid = '0;
   endtask

   initial begin
      req_valid   = '0;
      req_addr    = '0;
      req_data    = '0;
      claim_valid = 1'b0;
      claim_addr  = '0;
      test_reset();
      test_single();
      test_addr0();
      test_scoreboard();
      test_simultaneous();
      test_midstream_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
